// File: rtl/glut_stage_fifo_x4.sv
// Frame buffer for the self-calculating ADD/MUL block: stores 4xfp32 beats in order,
// returns them with one cycle of registered read latency, and reports fill/sticky error status.
module glut_stage_fifo_x4 #(
    parameter int unsigned DATA_NUM = 192,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                in_tvalid,
    input  logic [127:0]        in_tdata,
    input  logic                fifo_read_en,
    output logic                fifo_out_tvalid,
    output logic [127:0]        fifo_out_tdata,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                empty,
    output logic                frame_ready,
    output logic                overflow,
    output logic                underflow
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0]  count_d;
    logic              out_tvalid_d;
    logic [DATA_W-1:0] out_tdata_d;
    logic              overflow_d;
    logic              underflow_d;
    logic              wr_acc_c;
    logic              rd_acc_c;

    // Status decodes of the registered occupancy
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign frame_ready = (count >= CNT_W'(DATA_NUM));

    // Acceptance uses pre-access status: a read never frees room for a same-cycle write,
    // and a write never feeds a same-cycle read.
    assign wr_acc_c = in_tvalid && !full && !clr;
    assign rd_acc_c = fifo_read_en && !empty && !clr;

    always_comb begin
        wr_ptr_d     = wr_ptr;
        rd_ptr_d     = rd_ptr;
        count_d      = count;
        out_tvalid_d = 1'b0;
        out_tdata_d  = fifo_out_tdata;
        overflow_d   = overflow;
        underflow_d  = underflow;

        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr_d = wr_ptr + ADDR_W'(1);
            end
            if (rd_acc_c) begin
                rd_ptr_d     = rd_ptr + ADDR_W'(1);
                out_tvalid_d = 1'b1;
                out_tdata_d  = mem[rd_ptr];
            end
            if (in_tvalid && full) begin
                overflow_d = 1'b1;
            end
            if (fifo_read_en && empty) begin
                underflow_d = 1'b1;
            end
            case ({wr_acc_c, rd_acc_c})
                2'b10:   count_d = count + CNT_W'(1);
                2'b01:   count_d = count - CNT_W'(1);
                default: count_d = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            fifo_out_tvalid <= 1'b0;
            fifo_out_tdata  <= '0;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
        end else begin
            wr_ptr          <= wr_ptr_d;
            rd_ptr          <= rd_ptr_d;
            count           <= count_d;
            fifo_out_tvalid <= out_tvalid_d;
            fifo_out_tdata  <= out_tdata_d;
            overflow        <= overflow_d;
            underflow       <= underflow_d;
        end
    end

    // Storage array is deliberately left out of reset and clear
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem[wr_ptr] <= in_tdata;
        end
    end

endmodule

// File: tb/tb_glut_stage_fifo_x4.sv
// Directed bench for glut_stage_fifo_x4: a vector table for basic access patterns
// followed by hand-written frame, overflow, underflow, wrap, clear and reset sequences.
module tb_glut_stage_fifo_x4;

    localparam int unsigned DATA_NUM = 192;
    localparam int unsigned DEPTH    = 256;
    localparam int unsigned ADDR_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clr;
    logic               in_tvalid;
    logic [127:0]       in_tdata;
    logic               fifo_read_en;
    logic               fifo_out_tvalid;
    logic [127:0]       fifo_out_tdata;
    logic [ADDR_W:0]    count;
    logic               full;
    logic               empty;
    logic               frame_ready;
    logic               overflow;
    logic               underflow;

    int n_tests = 0;
    int n_fail  = 0;

    glut_stage_fifo_x4 #(
        .DATA_NUM (DATA_NUM),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clr             (clr),
        .in_tvalid       (in_tvalid),
        .in_tdata        (in_tdata),
        .fifo_read_en    (fifo_read_en),
        .fifo_out_tvalid (fifo_out_tvalid),
        .fifo_out_tdata  (fifo_out_tdata),
        .count           (count),
        .full            (full),
        .empty           (empty),
        .frame_ready     (frame_ready),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic [127:0] d;
        logic         rd;
        logic         c;
        logic         ev;
        logic [127:0] ed;
        int           ec;
        logic         eunf;
    } vec_t;

    vec_t tv [11];

    localparam logic [127:0] D1 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] D2 = 128'hDEADBEEF_00000000_FFFFFFFF_12345678;
    localparam logic [127:0] D3 = 128'h3F800000_40000000_40400000_40800000;
    localparam logic [127:0] D4 = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;
    localparam logic [127:0] D5 = 128'hCAFEBABE_87654321_00000001_80000000;
    localparam logic [127:0] DA5 = {16{8'hA5}};

    function automatic logic [127:0] beat(input int k);
        return {32'(k + 3), 32'(k + 2), 32'(k + 1), 32'(k)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input int ec, input logic eovf, input logic eunf);
        check($sformatf("%s count", tag), 128'(count), 128'(ec));
        check($sformatf("%s empty", tag), 128'(empty), 128'(ec == 0));
        check($sformatf("%s full", tag), 128'(full), 128'(ec == int'(DEPTH)));
        check($sformatf("%s frame_ready", tag), 128'(frame_ready), 128'(ec >= int'(DATA_NUM)));
        check($sformatf("%s overflow", tag), 128'(overflow), 128'(eovf));
        check($sformatf("%s underflow", tag), 128'(underflow), 128'(eunf));
    endtask

    // Apply inputs for one clock, then sample 1 time unit after the edge
    task automatic step(input logic w, input logic [127:0] d, input logic r, input logic c);
        in_tvalid    = w;
        in_tdata     = d;
        fifo_read_en = r;
        clr          = c;
        @(posedge clk);
        #1;
        in_tvalid    = 1'b0;
        fifo_read_en = 1'b0;
        clr          = 1'b0;
    endtask

    initial begin
        tv[0]  = '{1'b1, D1,     1'b0, 1'b0, 1'b0, 128'h0, 1, 1'b0};
        tv[1]  = '{1'b1, D2,     1'b0, 1'b0, 1'b0, 128'h0, 2, 1'b0};
        tv[2]  = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, D1,     1, 1'b0};
        tv[3]  = '{1'b1, D3,     1'b1, 1'b0, 1'b1, D2,     1, 1'b0};
        tv[4]  = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, D3,     0, 1'b0};
        tv[5]  = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b0, D3,     0, 1'b1};
        tv[6]  = '{1'b1, D4,     1'b1, 1'b0, 1'b0, D3,     1, 1'b1};
        tv[7]  = '{1'b0, 128'h0, 1'b0, 1'b1, 1'b0, D3,     0, 1'b0};
        tv[8]  = '{1'b0, 128'h0, 1'b0, 1'b0, 1'b0, D3,     0, 1'b0};
        tv[9]  = '{1'b1, D5,     1'b0, 1'b0, 1'b0, D3,     1, 1'b0};
        tv[10] = '{1'b0, 128'h0, 1'b1, 1'b0, 1'b1, D5,     0, 1'b0};

        rst_n        = 1'b1;
        clr          = 1'b0;
        in_tvalid    = 1'b0;
        in_tdata     = '0;
        fifo_read_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset tvalid", 128'(fifo_out_tvalid), 128'(0));
        check("reset tdata", fifo_out_tdata, 128'h0);
        check_status("reset", 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            step(tv[i].wr, tv[i].d, tv[i].rd, tv[i].c);
            check($sformatf("vec%0d tvalid", i), 128'(fifo_out_tvalid), 128'(tv[i].ev));
            check($sformatf("vec%0d tdata", i), fifo_out_tdata, tv[i].ed);
            check_status($sformatf("vec%0d", i), tv[i].ec, 1'b0, tv[i].eunf);
        end

        // Frame fill and drain
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < int'(DATA_NUM); i++) begin
            step(1'b1, beat(i), 1'b0, 1'b0);
            check($sformatf("fill%0d frame_ready", i), 128'(frame_ready), 128'(i == int'(DATA_NUM) - 1));
        end
        check("fill count", 128'(count), 128'(192));
        for (int j = 0; j < int'(DATA_NUM); j++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check($sformatf("drain%0d tvalid", j), 128'(fifo_out_tvalid), 128'(1));
            check($sformatf("drain%0d tdata", j), fifo_out_tdata, beat(j));
        end
        step(1'b0, '0, 1'b0, 1'b0);
        check("drain end tvalid", 128'(fifo_out_tvalid), 128'(0));
        check_status("drain end", 0, 1'b0, 1'b0);

        // Overflow: 257 writes into 256 entries
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 257; i++) begin
            step(1'b1, beat(i), 1'b0, 1'b0);
            if (i == 254) check("ovf full@255", 128'(full), 128'(0));
            if (i == 255) check_status("ovf full@256", 256, 1'b0, 1'b0);
        end
        check_status("ovf dropped", 256, 1'b1, 1'b0);
        for (int j = 0; j < 256; j++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check($sformatf("ovf rd%0d tdata", j), fifo_out_tdata, beat(j));
        end
        step(1'b0, '0, 1'b1, 1'b0);
        check("ovf extra tvalid", 128'(fifo_out_tvalid), 128'(0));
        check("ovf extra tdata", fifo_out_tdata, beat(255));
        check_status("ovf end", 0, 1'b1, 1'b1);

        // Underflow with same-cycle write, then simultaneous access at count 10
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, DA5, 1'b1, 1'b0);
        check("unf tvalid", 128'(fifo_out_tvalid), 128'(0));
        check_status("unf", 1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("unf next tvalid", 128'(fifo_out_tvalid), 128'(1));
        check("unf next tdata", fifo_out_tdata, DA5);
        for (int i = 0; i < 10; i++) step(1'b1, beat(2000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            step(1'b1, beat(2010 + i), 1'b1, 1'b0);
            check($sformatf("sim%0d tdata", i), fifo_out_tdata, beat(2000 + i));
            check($sformatf("sim%0d count", i), 128'(count), 128'(10));
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check($sformatf("sim tail%0d tdata", i), fifo_out_tdata, beat(2050 + i));
        end
        check_status("sim end", 0, 1'b0, 1'b1);

        // Pointer wrap across 255 -> 0
        step(1'b0, '0, 1'b0, 1'b1);
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int i = 0; i < 200; i++) step(1'b1, beat(3000 + rnd * 200 + i), 1'b0, 1'b0);
            check_status($sformatf("wrap%0d full", rnd), 200, 1'b0, 1'b0);
            for (int j = 0; j < 200; j++) begin
                step(1'b0, '0, 1'b1, 1'b0);
                check($sformatf("wrap%0d rd%0d tdata", rnd, j), fifo_out_tdata, beat(3000 + rnd * 200 + j));
            end
            check_status($sformatf("wrap%0d end", rnd), 0, 1'b0, 1'b0);
        end

        // Clear with simultaneous read and write
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b1, beat(4000 + i), 1'b0, 1'b0);
        check_status("clr pre", 50, 1'b0, 1'b1);
        step(1'b1, beat(9999), 1'b1, 1'b1);
        check("clr tvalid", 128'(fifo_out_tvalid), 128'(0));
        check_status("clr", 0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("clr write dropped tvalid", 128'(fifo_out_tvalid), 128'(0));
        check_status("clr write dropped", 0, 1'b0, 1'b1);

        // Asynchronous reset mid-stream at count 100
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 101; i++) step(1'b1, beat(500 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("prerst tdata", fifo_out_tdata, beat(500));
        check_status("prerst", 100, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst tvalid", 128'(fifo_out_tvalid), 128'(0));
        check("arst tdata", fifo_out_tdata, 128'h0);
        check_status("arst", 0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post rst empty", 128'(empty), 128'(1));
        step(1'b0, '0, 1'b1, 1'b0);
        check("post rst read tvalid", 128'(fifo_out_tvalid), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
